// File: rtl/adc_frame_reader.sv
// adc_frame_reader: captures framed MSB-first serial ADC words, tags each with its
// channel index and queues them in a small first-word-fall-through FIFO.
module adc_frame_reader #(
    parameter int unsigned DATA_WIDTH = 12,
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned FIFO_DEPTH = 4,
    localparam int unsigned CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sdata,
    input  logic                  start,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CH_W-1:0]       out_ch,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  overflow,
    input  logic                  clr_ovf
);

    localparam int unsigned BC_W  = $clog2(DATA_WIDTH);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [BC_W-1:0]  LastBit = BC_W'(DATA_WIDTH - 1);
    localparam logic [CH_W-1:0]  LastCh  = CH_W'(NUM_CH - 1);
    localparam logic [CNT_W-1:0] FullCnt = CNT_W'(FIFO_DEPTH);

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    state_e                r_state;
    logic [BC_W-1:0]       r_bit_cnt;
    logic [CH_W-1:0]       r_ch_cnt;
    // Only DATA_WIDTH-1 bits are stored; the final bit comes straight from sdata.
    logic [DATA_WIDTH-2:0] r_shreg;
    logic                  r_overflow;

    logic [DATA_WIDTH-1:0] r_mem_data [FIFO_DEPTH];
    logic [CH_W-1:0]       r_mem_ch   [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;

    logic [DATA_WIDTH-1:0] w_word;
    logic                  w_word_done;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_pop;
    logic                  w_wr_en;
    logic                  w_drop;

    assign w_word      = {r_shreg, sdata};
    assign w_word_done = (r_state == StShift) && (r_bit_cnt == LastBit);
    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == FullCnt);
    assign w_pop       = !w_empty && out_ready;
    // A full FIFO still accepts a word when the head leaves in the same cycle.
    assign w_wr_en     = w_word_done && (!w_full || w_pop);
    assign w_drop      = w_word_done && w_full && !w_pop;

    // Capture FSM: shift in serial bits, count bits within a word and words within a frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= StIdle;
            r_bit_cnt <= '0;
            r_ch_cnt  <= '0;
            r_shreg   <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (start) begin
                        r_shreg   <= w_word[DATA_WIDTH-2:0];
                        r_bit_cnt <= BC_W'(1);
                        r_ch_cnt  <= '0;
                        r_state   <= StShift;
                    end
                end
                StShift: begin
                    r_shreg <= w_word[DATA_WIDTH-2:0];
                    if (r_bit_cnt == LastBit) begin
                        r_bit_cnt <= '0;
                        if (r_ch_cnt == LastCh) begin
                            r_ch_cnt <= '0;
                            r_state  <= StIdle;
                        end else begin
                            r_ch_cnt <= r_ch_cnt + CH_W'(1);
                        end
                    end else begin
                        r_bit_cnt <= r_bit_cnt + BC_W'(1);
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    // FIFO storage; entries are reset so the head never reads X.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                r_mem_data[i] <= '0;
                r_mem_ch[i]   <= '0;
            end
        end else if (w_wr_en) begin
            r_mem_data[r_wr_ptr] <= w_word;
            r_mem_ch[r_wr_ptr]   <= r_ch_cnt;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_wr_en && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_wr_en && w_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    // Sticky overflow; a drop in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (clr_ovf) begin
            r_overflow <= 1'b0;
        end
    end

    assign out_data  = r_mem_data[r_rd_ptr];
    assign out_ch    = r_mem_ch[r_rd_ptr];
    assign out_valid = !w_empty;
    assign busy      = (r_state == StShift);
    assign overflow  = r_overflow;

endmodule
